inst_fetch_unit: RTL and testbench

//  Fetch-side initiator for the combinational instruction memory (addr -> data_out, word index = addr/4).

---
 rtl/inst_fetch_unit.sv | 79 +++++++
 tb/tb_inst_fetch_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Fetch stage of the pipelined RV32I core: owns the PC, reads the combinational
// instruction memory and fills the IF/ID register, with stall, redirect/flush and fault handling.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 256,
    parameter logic [31:0] NOP_INST   = 32'h0000_0033
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_inst,
    output logic        fetch_fault
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

    state_t      state;
    logic [31:0] pc;
    logic        in_range;
    logic [31:0] pc_next_seq;

    assign imem_addr   = pc;
    assign in_range    = (pc < IMEM_LIMIT);
    assign pc_next_seq = pc + 32'd4;

    // Priority: redirect, then fault hold, then stall, then normal fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= RESET_PC;
            state          <= RUN;
            if_id_valid    <= 1'b0;
            if_id_pc       <= 32'd0;
            if_id_pc_plus4 <= 32'd0;
            if_id_inst     <= NOP_INST;
            fetch_fault    <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= redirect_target;
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
            if (redirect_target[1:0] == 2'b00) begin
                state       <= RUN;
                fetch_fault <= 1'b0;
            end else begin
                state       <= FAULT;
                fetch_fault <= 1'b1;
            end
        end else if (state == FAULT) begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
        end else if (stall) begin
            pc <= pc;
        end else if (in_range) begin
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_next_seq;
            if_id_inst     <= imem_data;
            if_id_valid    <= 1'b1;
            pc             <= pc_next_seq;
        end else begin
            // Ran off the end of instruction memory: park here until redirected.
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
            state       <= FAULT;
            fetch_fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios then random stall/redirect traffic,
// compared against a rule-level model of the fetch stage.
module tb_inst_fetch_unit;

    localparam logic [31:0] NOP   = 32'h0000_0033;
    localparam logic [31:0] INS_A = 32'h0010_0093;
    localparam logic [31:0] INS_B = 32'h0020_0113;
    localparam logic [31:0] INS_C = 32'h0030_0193;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_inst;
    logic        fetch_fault;

    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    // model state
    logic [31:0] m_pc;
    logic        m_fault;
    logic        m_valid;
    logic [31:0] m_ifpc;
    logic [31:0] m_inst;

    inst_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_BYTES(256),
        .NOP_INST  (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_inst     (if_id_inst),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 32'd256) ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'd0;
        m_fault = 1'b0;
        m_valid = 1'b0;
        m_ifpc  = 32'd0;
        m_inst  = NOP;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        chk({tag, ".fault"}, {31'd0, fetch_fault}, {31'd0, m_fault});
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        chk({tag, ".inst"}, if_id_inst, m_inst);
        if (m_valid) begin
            chk({tag, ".pc"}, if_id_pc, m_ifpc);
            chk({tag, ".pc4"}, if_id_pc_plus4, m_ifpc + 32'd4);
        end
    endtask

    // One clock edge with the given inputs; model applies the fetch rules, then outputs are compared.
    task automatic step(input string tag, input logic s, input logic rv, input logic [31:0] tgt);
        stall           = s;
        redirect_valid  = rv;
        redirect_target = tgt;
        @(posedge clk);
        if (rv) begin
            m_valid = 1'b0;
            m_inst  = NOP;
            m_pc    = tgt;
            m_fault = (tgt % 4) != 0;
        end else if (m_fault) begin
            m_valid = 1'b0;
            m_inst  = NOP;
        end else if (!s) begin
            if (m_pc < 32'd256) begin
                m_ifpc  = m_pc;
                m_inst  = mem[m_pc / 4];
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end else begin
                m_valid = 1'b0;
                m_inst  = NOP;
                m_fault = 1'b1;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = INS_A;
        mem[1] = INS_B;
        mem[2] = INS_C;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;
        rst = 1'b1;
        model_reset();
        #2;
        check_all("reset");
        chk("reset.pc", if_id_pc, 32'd0);
        chk("reset.pc4", if_id_pc_plus4, 32'd0);
        #10 rst = 1'b0;

        // sequential fetch
        step("seq0", 0, 0, 0);
        chk("seq0.instA", if_id_inst, INS_A);
        step("seq1", 0, 0, 0);
        chk("seq1.instB", if_id_inst, INS_B);
        // stall holds IF/ID and PC
        step("stall0", 1, 0, 0);
        step("stall1", 1, 0, 0);
        chk("stall1.addr", imem_addr, 32'd8);
        step("seq2", 0, 0, 0);
        chk("seq2.instC", if_id_inst, INS_C);
        // redirect overrides stall
        step("redir_st", 1, 1, 32'h4);
        chk("redir_st.nop", if_id_inst, NOP);
        step("redir_st.after", 0, 0, 0);
        chk("redir_st.instB", if_id_inst, INS_B);
        // misaligned redirect faults, realigned redirect recovers
        step("mis", 0, 1, 32'h22);
        chk("mis.fault", {31'd0, fetch_fault}, 32'd1);
        step("mis.hold", 0, 0, 0);
        step("mis.hold_st", 1, 0, 0);
        step("recover", 0, 1, 32'h0);
        step("recover.a", 0, 0, 0);
        chk("recover.instA", if_id_inst, INS_A);
        // run off the end of memory
        step("end.redir", 0, 1, 32'hF0);
        for (int i = 0; i < 6; i++) step("end.run", 0, 0, 0);
        chk("end.addr", imem_addr, 32'h100);
        chk("end.fault", {31'd0, fetch_fault}, 32'd1);

        // async reset mid-cycle while valid
        step("pre_rst.redir", 0, 1, 32'h10);
        step("pre_rst.fetch", 0, 0, 0);
        step("pre_rst.fetch2", 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.pc", if_id_pc, 32'd0);
        chk("async_rst.pc4", if_id_pc_plus4, 32'd0);
        #3 rst = 1'b0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic        s;
            logic        rv;
            logic [31:0] tgt;
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 9) == 0);
            tgt = {22'd0, 10'($urandom_range(0, 270))};
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 30) == 0) tgt = 32'hFFFF_FFFC;
            step("rand", s, rv, tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
